// File: rtl/qec_rep_decoder.sv
// Multi-round majority-voted, serial minimum-weight decoder for a bit-flip repetition code.
// Optional on-chip syndrome LFSR is built only when QEC_LFSR_TEST_EN is defined.
module qec_rep_decoder #(
  parameter int N_DATA = 5,
  parameter int ROUNDS = 3,
  parameter int CNT_W  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          syn_valid,
  output logic                          syn_ready,
  input  logic [N_DATA-2:0]             syn,
  input  logic                          test_mode,
  input  logic                          clear_stats,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [N_DATA-1:0]             correction,
  output logic [$clog2(N_DATA+1)-1:0]   corr_weight,
  output logic                          err_flag,
  output logic                          uncorrectable,
  output logic                          meas_flag,
  output logic [CNT_W-1:0]              err_count
);

  localparam int SW = N_DATA - 1;
  localparam int OW = $clog2(ROUNDS + 1);
  localparam int CW = $clog2(N_DATA + 1);
  localparam logic [CW:0] N_WIDE = (CW+1)'(N_DATA);

  typedef enum logic [1:0] {COLLECT, DECODE, RESOLVE, OUTPUT} state_t;

  state_t          state, next;
  logic [OW-1:0]   ones [SW];
  logic [OW-1:0]   round_cnt;
  logic [CW-1:0]   step;
  logic [SW-1:0]   v_reg, v_now, syn_src;
  logic            meas_reg, split_now;
  logic [N_DATA-1:0] cand;
  logic            cur_bit, chain_bit;
  logic [CW-1:0]   w_a;
  logic [CW:0]     two_wa;
  logic            last_round;

`ifdef QEC_LFSR_TEST_EN
  logic [15:0] lfsr;

  // Galois form of x^16+x^14+x^13+x^11+1, stepped once per accepted test round
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      lfsr <= 16'hACE1;
    else if (state == COLLECT && syn_valid && test_mode)
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  end

  assign syn_src = test_mode ? lfsr[SW-1:0] : syn;
`else
  logic unused_test_mode;
  assign unused_test_mode = test_mode;
  assign syn_src = syn;
`endif

  assign last_round = (round_cnt == OW'(ROUNDS - 1));
  assign two_wa     = {w_a, 1'b0};

  always_comb begin
    v_now     = '0;
    split_now = 1'b0;
    for (int k = 0; k < SW; k++) begin
      v_now[k] = (ones[k] > OW'(ROUNDS / 2));
      if (ones[k] != '0 && ones[k] != OW'(ROUNDS))
        split_now = 1'b1;
    end
  end

  // Next chain bit c[step] = c[step-1] ^ v[step-1]
  always_comb begin
    chain_bit = cur_bit;
    for (int k = 0; k < SW; k++)
      if (step == CW'(k + 1))
        chain_bit = cur_bit ^ v_reg[k];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= COLLECT;
    else     state <= next;
  end

  always_comb begin
    next      = state;
    syn_ready = 1'b0;
    res_valid = 1'b0;
    unique case (state)
      COLLECT: begin
        syn_ready = 1'b1;
        if (syn_valid && last_round) next = DECODE;
      end
      DECODE:  if (step == CW'(N_DATA - 1)) next = RESOLVE;
      RESOLVE: next = OUTPUT;
      OUTPUT: begin
        res_valid = 1'b1;
        if (res_ready) next = COLLECT;
      end
      default: next = COLLECT;
    endcase
  end

  // DECODE step 0 snapshots the votes; steps 1..N_DATA-1 walk the parity chain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < SW; k++) ones[k] <= '0;
      round_cnt     <= '0;
      step          <= '0;
      v_reg         <= '0;
      meas_reg      <= 1'b0;
      cand          <= '0;
      cur_bit       <= 1'b0;
      w_a           <= '0;
      correction    <= '0;
      corr_weight   <= '0;
      err_flag      <= 1'b0;
      uncorrectable <= 1'b0;
      meas_flag     <= 1'b0;
    end else begin
      unique case (state)
        COLLECT: begin
          step <= '0;
          if (syn_valid) begin
            for (int k = 0; k < SW; k++) ones[k] <= ones[k] + OW'(syn_src[k]);
            round_cnt <= last_round ? '0 : round_cnt + 1'b1;
          end
        end
        DECODE: begin
          step <= step + 1'b1;
          if (step == '0) begin
            v_reg    <= v_now;
            meas_reg <= split_now;
            cand     <= '0;
            cur_bit  <= 1'b0;
            w_a      <= '0;
          end else begin
            cur_bit <= chain_bit;
            w_a     <= w_a + CW'(chain_bit);
            for (int k = 1; k < N_DATA; k++)
              if (step == CW'(k)) cand[k] <= chain_bit;
          end
        end
        RESOLVE: begin
          err_flag  <= |v_reg;
          meas_flag <= meas_reg;
          if (two_wa < N_WIDE) begin
            correction    <= cand;
            corr_weight   <= w_a;
            uncorrectable <= 1'b0;
          end else if (two_wa > N_WIDE) begin
            correction    <= ~cand;
            corr_weight   <= CW'(N_DATA) - w_a;
            uncorrectable <= 1'b0;
          end else begin
            correction    <= '0;
            corr_weight   <= '0;
            uncorrectable <= 1'b1;
          end
        end
        OUTPUT: begin
          if (res_ready)
            for (int k = 0; k < SW; k++) ones[k] <= '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err_count <= '0;
    else if (clear_stats)
      err_count <= '0;
    else if (state == OUTPUT && res_ready && err_flag && !uncorrectable && err_count != '1)
      err_count <= err_count + 1'b1;
  end

endmodule

// File: tb/tb_qec_rep_decoder.sv
// Scoreboard bench: main DUT (N_DATA=5, ROUNDS=3, CNT_W=2) plus an N_DATA=4 instance for the tie case.
module tb_qec_rep_decoder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       syn_valid, syn_ready, test_mode, clear_stats, res_valid, res_ready;
  logic [3:0] syn;
  logic [4:0] correction;
  logic [2:0] corr_weight;
  logic       err_flag, uncorrectable, meas_flag;
  logic [1:0] err_count;

  logic       tie_syn_valid, tie_syn_ready, tie_res_valid, tie_res_ready;
  logic [2:0] tie_syn;
  logic [3:0] tie_correction;
  logic [2:0] tie_corr_weight;
  logic       tie_err_flag, tie_uncorrectable, tie_meas_flag;
  logic [7:0] tie_err_count;

  qec_rep_decoder #(.N_DATA(5), .ROUNDS(3), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .syn_valid(syn_valid), .syn_ready(syn_ready), .syn(syn),
    .test_mode(test_mode), .clear_stats(clear_stats), .res_valid(res_valid),
    .res_ready(res_ready), .correction(correction), .corr_weight(corr_weight),
    .err_flag(err_flag), .uncorrectable(uncorrectable), .meas_flag(meas_flag),
    .err_count(err_count)
  );

  qec_rep_decoder #(.N_DATA(4), .ROUNDS(3), .CNT_W(8)) dut_tie (
    .clk(clk), .rst(rst), .syn_valid(tie_syn_valid), .syn_ready(tie_syn_ready),
    .syn(tie_syn), .test_mode(1'b0), .clear_stats(1'b0), .res_valid(tie_res_valid),
    .res_ready(tie_res_ready), .correction(tie_correction), .corr_weight(tie_corr_weight),
    .err_flag(tie_err_flag), .uncorrectable(tie_uncorrectable), .meas_flag(tie_meas_flag),
    .err_count(tie_err_count)
  );

  typedef struct {
    logic [4:0] corr;
    int         wt;
    logic       err;
    logic       unc;
    logic       meas;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   edge_cnt = 0;
  int   accept_edge = 0;
  int   model_cnt = 0;

  always @(posedge clk) edge_cnt++;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  // Reference decoder: majority vote, parity-chain candidate, minimum-weight choice
  function automatic exp_t model(input logic [3:0] r0, r1, r2, input int n);
    exp_t       e;
    logic [3:0] v;
    logic [4:0] a, m;
    int         w, ones;
    v = '0;
    e.meas = 1'b0;
    for (int k = 0; k < n - 1; k++) begin
      ones = int'(r0[k]) + int'(r1[k]) + int'(r2[k]);
      v[k] = (ones >= 2);
      if (ones == 1 || ones == 2) e.meas = 1'b1;
    end
    a = '0;
    for (int i = 1; i < n; i++) a[i] = a[i-1] ^ v[i-1];
    w = 0;
    for (int i = 0; i < n; i++) w += int'(a[i]);
    m = 5'((1 << n) - 1);
    e.err = |v;
    e.unc = 1'b0;
    if (2 * w < n) begin
      e.corr = a;
      e.wt   = w;
    end else if (2 * w > n) begin
      e.corr = ~a & m;
      e.wt   = n - w;
    end else begin
      e.corr = '0;
      e.wt   = 0;
      e.unc  = 1'b1;
    end
    return e;
  endfunction

  task automatic sendRound(input logic [3:0] s, input int gap);
    int n = 0;
    for (int g = 0; g < gap; g++) begin
      syn_valid = 1'b0;
      syn = 4'($urandom);
      @(negedge clk);
    end
    syn = s;
    syn_valid = 1'b1;
    while (!syn_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!syn_ready) checkOutput("syn_ready_timeout", 32'(syn_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    syn_valid = 1'b0;
    accept_edge = edge_cnt;
  endtask

  task automatic applyStimulus(input logic [3:0] r0, r1, r2, input int gap);
    sendRound(r0, gap);
    sendRound(r1, gap);
    sendRound(r2, gap);
    sb.push_back(model(r0, r1, r2, 5));
  endtask

  task automatic collectResult(input int hold, input bit clr, input bit check_lat);
    exp_t e;
    int   n = 0;
    if (sb.size() == 0) begin
      checkOutput("scoreboard_empty", 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    while (!res_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!res_valid) begin
      checkOutput("res_valid_timeout", 32'(res_valid), 32'd1);
      return;
    end
    if (check_lat) checkOutput("latency", 32'(edge_cnt - accept_edge), 32'd6);
    checkOutput("correction", 32'(correction), 32'(e.corr));
    checkOutput("corr_weight", 32'(corr_weight), 32'(e.wt));
    checkOutput("err_flag", 32'(err_flag), 32'(e.err));
    checkOutput("uncorrectable", 32'(uncorrectable), 32'(e.unc));
    checkOutput("meas_flag", 32'(meas_flag), 32'(e.meas));
    for (int h = 0; h < hold; h++) begin
      syn_valid = 1'b1;
      syn = 4'($urandom);
      @(negedge clk);
      checkOutput("hold_res_valid", 32'(res_valid), 32'd1);
      checkOutput("hold_correction", 32'(correction), 32'(e.corr));
      checkOutput("hold_syn_ready", 32'(syn_ready), 32'd0);
    end
    syn_valid   = 1'b0;
    clear_stats = clr;
    res_ready   = 1'b1;
    @(posedge clk);
    if (clr) model_cnt = 0;
    else if (e.err && !e.unc && model_cnt < 3) model_cnt++;
    @(negedge clk);
    res_ready   = 1'b0;
    clear_stats = 1'b0;
    checkOutput("err_count", 32'(err_count), 32'(model_cnt));
    checkOutput("res_valid_after_hs", 32'(res_valid), 32'd0);
    checkOutput("syn_ready_after_hs", 32'(syn_ready), 32'd1);
  endtask

  initial begin
    logic [3:0] ra, rb, rc;
    int         n;
    rst = 1'b1;
    syn_valid = 1'b0; syn = '0; test_mode = 1'b0; clear_stats = 1'b0; res_ready = 1'b0;
    tie_syn_valid = 1'b0; tie_syn = '0; tie_res_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_syn_ready", 32'(syn_ready), 32'd1);
    checkOutput("reset_res_valid", 32'(res_valid), 32'd0);
    checkOutput("reset_correction", 32'(correction), 32'd0);
    checkOutput("reset_flags", 32'({err_flag, uncorrectable, meas_flag}), 32'd0);
    checkOutput("reset_err_count", 32'(err_count), 32'd0);

    applyStimulus(4'b0110, 4'b0110, 4'b0110, 0);
    collectResult(0, 1'b0, 1'b1);
    applyStimulus(4'b0001, 4'b0001, 4'b0001, 0);
    collectResult(0, 1'b0, 1'b1);
    applyStimulus(4'b0110, 4'b0110, 4'b0000, 0);
    collectResult(0, 1'b0, 1'b0);
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 0);
    collectResult(0, 1'b0, 1'b0);
    applyStimulus(4'b0110, 4'b0110, 4'b0110, 3);
    collectResult(0, 1'b0, 1'b1);
    applyStimulus(4'b0001, 4'b0001, 4'b0001, 0);
    collectResult(10, 1'b1, 1'b1);

    for (int t = 0; t < 6; t++) begin
      ra = 4'($urandom); rb = 4'($urandom); rc = 4'($urandom);
      applyStimulus(ra, rb, rc, t % 2);
      collectResult(t % 3, 1'b0, 1'b1);
    end

    sendRound(4'b1000, 0);
    sendRound(4'b1000, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_cnt = 0;
    checkOutput("midrst_syn_ready", 32'(syn_ready), 32'd1);
    checkOutput("midrst_res_valid", 32'(res_valid), 32'd0);
    checkOutput("midrst_correction", 32'(correction), 32'd0);
    checkOutput("midrst_corr_weight", 32'(corr_weight), 32'd0);
    checkOutput("midrst_flags", 32'({err_flag, uncorrectable, meas_flag}), 32'd0);
    checkOutput("midrst_err_count", 32'(err_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    applyStimulus(4'b0001, 4'b0001, 4'b0001, 0);
    collectResult(0, 1'b0, 1'b1);

    // Even-distance instance: a single interior syndrome bit ties the two candidates
    tie_syn = 3'b010;
    for (int r = 0; r < 3; r++) begin
      tie_syn_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    tie_syn_valid = 1'b0;
    n = 0;
    while (!tie_res_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("tie_res_valid", 32'(tie_res_valid), 32'd1);
    checkOutput("tie_uncorrectable", 32'(tie_uncorrectable),
                32'(model({1'b0, tie_syn}, {1'b0, tie_syn}, {1'b0, tie_syn}, 4).unc));
    checkOutput("tie_correction", 32'(tie_correction), 32'd0);
    checkOutput("tie_corr_weight", 32'(tie_corr_weight), 32'd0);
    checkOutput("tie_err_flag", 32'(tie_err_flag), 32'd1);
    checkOutput("tie_meas_flag", 32'(tie_meas_flag), 32'd0);
    tie_res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tie_res_ready = 1'b0;
    checkOutput("tie_err_count", 32'(tie_err_count), 32'd0);
    checkOutput("tie_syn_ready", 32'(tie_syn_ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
